div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requesters (fixed at 2 in this revision).
REQ-002 SHALL have parameter DIV0_Q, default 8'hFF, quotient returned on divide-by-zero.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req0, req1  in  1 each  request, held high until that port's done.
REQ-006 dividend0, divisor0, dividend1, divisor1  in  8 each  signed operands per port.
REQ-007 gnt0, gnt1  out  1 each  high from grant edge through the done cycle.
REQ-008 done0, done1  out  1 each  one-cycle result-valid pulse.
REQ-009 err0, err1  out  1 each  divide-by-zero flag, valid with done.
REQ-010 quotient, remainder  out  8 each  shared result bus; holds last result until the next done.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-013 IDLE: if any req is high, SHALL grant one port, latch its operands and assert its gnt at that edge.
REQ-014 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not served last; after reset, port 0 wins.
REQ-015 IDLE with granted divisor == 0 SHALL go directly to DONE with quotient = DIV0_Q, remainder = dividend, err = 1; the core SHALL NOT start.
REQ-016 IDLE with a non-zero divisor SHALL go to ISSUE.
REQ-017 ISSUE SHALL drive core start high with the latched operands and move to WAIT only on an edge where core ready is high.
REQ-018 While core ready is low in ISSUE (core still busy from a pre-reset operation), ISSUE SHALL hold.
REQ-019 WAIT SHALL ignore core ready on its first edge, then go to DONE on the first edge where core ready is high, capturing the core quotient and remainder.
REQ-020 DONE SHALL pulse done and err for exactly one cycle on the granted port, deassert gnt at the next edge, update the last-served pointer, and return to IDLE.
REQ-021 Latency for a non-zero divisor with an idle core: done SHALL be high in the cycle after the 10th rising edge following the grant edge.
REQ-022 Divide-by-zero latency: done SHALL be high in the cycle after the grant edge.
REQ-023 The requester with no grant SHALL see its gnt, done and err held at 0.
REQ-024 Requests arriving or dropping outside IDLE SHALL NOT affect the operation in flight.
REQ-025 Back-to-back operations: a req still high in the IDLE cycle after DONE SHALL be eligible for arbitration.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE; gnt, done, err and busy = 0; quotient and remainder = 0; last-served pointer set so port 0 wins next.
REQ-027 Reset mid-operation SHALL abort the transaction with no done; the next start SHALL be deferred per REQ-018.

Structure
REQ-028 Package div_ctrl_pkg SHALL hold the FSM state typedef, N_PORTS and DIV0_Q.
REQ-029 SHALL instantiate exactly one sub-module: the existing 8-bit iterative signed core, divider.
REQ-030 The core's ports SHALL be driven only by this block.

Verification
REQ-031 req0 with 100 / 7 -> gnt0 at the grant edge; done0 after 10 edges; quotient = 14, remainder = 2, err0 = 0.
REQ-032 req0 and req1 high together from reset, with 50 / 5 and 9 / 2 -> port 0 served first (q = 10, r = 0), then port 1 (q = 4, r = 1); no overlapping gnt.
REQ-033 req1 with 37 / 0 -> done1 in the cycle after grant; quotient = 8'hFF, remainder = 37, err1 = 1; core start never asserted.
REQ-034 req0 held continuously while req1 also requests -> grants alternate 0, 1, 0, 1.
REQ-035 rst_n pulsed low 3 edges into an operation -> outputs zero immediately, no done; a new req0 of 20 / 3 waits for core ready and returns q = 6, r = 2.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider request arbiter.
package div_ctrl_pkg;

  localparam int unsigned N_PORTS = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam logic [DATA_W-1:0] DIV0_Q = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/div_arbiter_divider.sv
// 8-bit iterative signed divider: restoring division on magnitudes, one
// quotient bit per clock, sign fix-up folded into the final iteration.
// The counter has no reset on purpose: an operation in flight survives the
// controller's reset, and any power-up value drains down to zero (ready).
module divider
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dmag;
  logic              neg_q;
  logic              neg_r;

  logic [DATA_W:0]   trial;
  logic              fits;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] acc_nxt;

  assign ready = (cnt == CNT_W'(0));

  // One restoring-division step on the current partial remainder.
  always_comb begin
    trial   = {rem, acc[DATA_W-1]};
    fits    = (trial >= {1'b0, dmag});
    rem_nxt = fits ? DATA_W'(trial - {1'b0, dmag}) : trial[DATA_W-1:0];
    acc_nxt = {acc[DATA_W-2:0], fits};
  end

  // Load magnitudes on start, iterate, publish signed results on the last step.
  always_ff @(posedge clk) begin
    if (cnt == CNT_W'(0)) begin
      if (start) begin
        acc   <= dividend[DATA_W-1] ? DATA_W'(-dividend) : dividend;
        dmag  <= divisor[DATA_W-1] ? DATA_W'(-divisor) : divisor;
        rem   <= '0;
        neg_q <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
        neg_r <= dividend[DATA_W-1];
        cnt   <= CNT_W'(DATA_W);
      end
    end else begin
      acc <= acc_nxt;
      rem <= rem_nxt;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        quotient  <= neg_q ? DATA_W'(-acc_nxt) : acc_nxt;
        remainder <= neg_r ? DATA_W'(-rem_nxt) : rem_nxt;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Two-port round-robin arbiter in front of a shared iterative signed divider.
// Divide-by-zero is answered locally without touching the core.
module div_arbiter #(
  parameter int unsigned N_PORTS = div_ctrl_pkg::N_PORTS,
  parameter logic [7:0]  DIV0_Q  = div_ctrl_pkg::DIV0_Q
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] dividend0,
  input  logic [7:0] divisor0,
  input  logic [7:0] dividend1,
  input  logic [7:0] divisor1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy
);
  import div_ctrl_pkg::*;

  localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  state_t            state;
  logic [PTR_W-1:0]  last_port;
  logic [PTR_W-1:0]  cur_port;
  logic [PTR_W-1:0]  pick;
  logic [DATA_W-1:0] pick_dd;
  logic [DATA_W-1:0] pick_dv;
  logic [DATA_W-1:0] op_dd;
  logic [DATA_W-1:0] op_dv;
  logic              first_wait;

  logic              core_start;
  logic              core_ready;
  logic [DATA_W-1:0] core_q;
  logic [DATA_W-1:0] core_r;

  assign core_start = (state == ISSUE);

  // Round-robin choice: on a tie the port not served last wins.
  always_comb begin
    if (req0 && req1) begin
      pick = (last_port == PTR_W'(0)) ? PTR_W'(1) : PTR_W'(0);
    end else if (req1) begin
      pick = PTR_W'(1);
    end else begin
      pick = PTR_W'(0);
    end
    pick_dd = (pick == PTR_W'(1)) ? dividend1 : dividend0;
    pick_dv = (pick == PTR_W'(1)) ? divisor1  : divisor0;
  end

  // Controller FSM with registered grant, pulse and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_port  <= PTR_W'(1);
      cur_port   <= PTR_W'(0);
      op_dd      <= '0;
      op_dv      <= '0;
      first_wait <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      busy       <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            cur_port <= pick;
            op_dd    <= pick_dd;
            op_dv    <= pick_dv;
            gnt0     <= (pick == PTR_W'(0));
            gnt1     <= (pick == PTR_W'(1));
            busy     <= 1'b1;
            if (pick_dv == '0) begin
              quotient  <= DIV0_Q;
              remainder <= pick_dd;
              done0     <= (pick == PTR_W'(0));
              done1     <= (pick == PTR_W'(1));
              err0      <= (pick == PTR_W'(0));
              err1      <= (pick == PTR_W'(1));
              state     <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (core_ready) begin
            first_wait <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (core_ready) begin
            quotient  <= core_q;
            remainder <= core_r;
            done0     <= (cur_port == PTR_W'(0));
            done1     <= (cur_port == PTR_W'(1));
            state     <= DONE;
          end
        end
        DONE: begin
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          busy      <= 1'b0;
          last_port <= cur_port;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  divider u_core (
    .clk       (clk),
    .start     (core_start),
    .dividend  (op_dd),
    .divisor   (op_dv),
    .ready     (core_ready),
    .quotient  (core_q),
    .remainder (core_r)
  );

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed table, hand sequences for
// alternation and mid-operation reset, and randomized batches vs. a model.
module tb_div_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] dividend0 = '0, divisor0 = '0, dividend1 = '0, divisor1 = '0;
  logic       gnt0, gnt1, done0, done1, err0, err1, busy;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic model_last = 1'b1;

  typedef struct {
    logic signed [7:0] dd;
    logic signed [7:0] dv;
    logic [7:0]        q;
    logic [7:0]        r;
    logic              err;
    int                lat;
  } op_t;

  typedef struct {
    logic [1:0] mask;
    op_t        o0;
    op_t        o1;
  } vec_t;

  vec_t tbl[9];

  div_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .dividend0 (dividend0),
    .divisor0  (divisor0),
    .dividend1 (dividend1),
    .divisor1  (divisor1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .err0      (err0),
    .err1      (err1),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count clock edges on which the core is being asked to start.
  always @(posedge clk) if (dut.core_start) start_cnt <= start_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic signed [7:0] dd, input logic signed [7:0] dv,
                             input logic [7:0] q, input logic [7:0] r,
                             input logic err, input int lat);
    op_t o;
    o.dd = dd; o.dv = dv; o.q = q; o.r = r; o.err = err; o.lat = lat;
    return o;
  endfunction

  // Reference: truncating signed division; divide-by-zero answered at once.
  function automatic op_t model_op(input logic signed [7:0] dd, input logic signed [7:0] dv);
    op_t o;
    o.dd = dd; o.dv = dv;
    if (dv == 0) begin
      o.q = 8'hFF; o.r = dd; o.err = 1'b1; o.lat = 0;
    end else begin
      o.q = 8'(int'(dd) / int'(dv));
      o.r = 8'(int'(dd) % int'(dv));
      o.err = 1'b0; o.lat = 10;
    end
    return o;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  // Raise the requested ports together and serve them in arbitration order.
  task automatic run_batch(input logic [1:0] mask, input op_t o0, input op_t o1);
    logic [1:0] pending;
    int exp_port, port, n, lat, s0;
    op_t e;
    dividend0 = o0.dd; divisor0 = o0.dv;
    dividend1 = o1.dd; divisor1 = o1.dv;
    req0 = mask[0]; req1 = mask[1];
    pending = mask;
    while (pending != 2'b00) begin
      exp_port = (pending == 2'b11) ? int'(!model_last) : (pending[1] ? 1 : 0);
      n = 0;
      while (!(gnt0 || gnt1) && n < 20) begin @(posedge clk); #1; n++; end
      if (!(gnt0 || gnt1)) begin
        chk("grant_timeout", 0, 1);
        req0 = 1'b0; req1 = 1'b0;
        return;
      end
      port = gnt1 ? 1 : 0;
      chk("grant_port", port, exp_port);
      chk("gnt_exclusive", int'(gnt0 && gnt1), 0);
      chk("busy_active", int'(busy), 1);
      e = port ? o1 : o0;
      s0 = start_cnt;
      lat = 0;
      while (!(done0 || done1) && lat < 40) begin @(posedge clk); #1; lat++; end
      if (!(done0 || done1)) begin
        chk("done_timeout", 0, 1);
        req0 = 1'b0; req1 = 1'b0;
        return;
      end
      chk("done_port", done1 ? 1 : 0, port);
      chk("latency", lat, e.lat);
      chk("quotient", int'(quotient), int'(e.q));
      chk("remainder", int'(remainder), int'(e.r));
      chk("err", int'(port ? err1 : err0), int'(e.err));
      chk("other_port_quiet", int'(port ? (gnt0 | done0 | err0) : (gnt1 | done1 | err1)), 0);
      chk("core_starts", start_cnt - s0, (e.dv == 0) ? 0 : 1);
      if (port == 1) req1 = 1'b0; else req0 = 1'b0;
      pending[port] = 1'b0;
      model_last = port[0];
      @(posedge clk); #1;
      chk("gnt_released", int'(gnt0 | gnt1 | done0 | done1), 0);
      chk("busy_idle", int'(busy), 0);
      chk("result_held", int'(quotient), int'(e.q));
    end
  endtask

  initial begin
    op_t z, a, b;
    int port, n, lat;
    z = mk(8'sd0, 8'sd0, 8'h00, 8'h00, 1'b0, 0);

    tbl[0] = '{2'b11, mk(8'sd50, 8'sd5, 8'd10, 8'd0, 1'b0, 10), mk(8'sd9, 8'sd2, 8'd4, 8'd1, 1'b0, 10)};
    tbl[1] = '{2'b01, mk(8'sd100, 8'sd7, 8'd14, 8'd2, 1'b0, 10), z};
    tbl[2] = '{2'b10, z, mk(8'sd37, 8'sd0, 8'hFF, 8'd37, 1'b1, 0)};
    tbl[3] = '{2'b01, mk(-8'sd100, 8'sd7, 8'hF2, 8'hFE, 1'b0, 10), z};
    tbl[4] = '{2'b10, z, mk(8'sd100, -8'sd7, 8'hF2, 8'h02, 1'b0, 10)};
    tbl[5] = '{2'b01, mk(-8'sd128, -8'sd1, 8'h80, 8'h00, 1'b0, 10), z};
    tbl[6] = '{2'b01, mk(-8'sd7, 8'sd0, 8'hFF, 8'hF9, 1'b1, 0), z};
    tbl[7] = '{2'b10, z, mk(8'sd127, -8'sd128, 8'h00, 8'h7F, 1'b0, 10)};
    tbl[8] = '{2'b11, mk(-8'sd128, 8'sd7, 8'hEE, 8'hFE, 1'b0, 10), mk(8'sd0, 8'sd5, 8'h00, 8'h00, 1'b0, 10)};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt0 | gnt1), 0);
    chk("rst_done_err", int'(done0 | done1 | err0 | err1), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    rst_n = 1'b1;
    model_last = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) run_batch(tbl[i].mask, tbl[i].o0, tbl[i].o1);

    // req0 held continuously with req1 also requesting: grants alternate
    do_reset();
    dividend0 = 8'd12; divisor0 = 8'd3; dividend1 = 8'd12; divisor1 = 8'd3;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(gnt0 || gnt1) && n < 20) begin @(posedge clk); #1; n++; end
      port = gnt1 ? 1 : 0;
      chk("alternate_grant", port, k % 2);
      chk("alternate_excl", int'(gnt0 && gnt1), 0);
      n = 0;
      while (!(done0 || done1) && n < 40) begin @(posedge clk); #1; n++; end
      chk("alternate_done", int'(done0 || done1), 1);
      chk("alternate_q", int'(quotient), 4);
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      @(posedge clk); #1;
    end
    model_last = 1'b1;

    // Randomized batches against the model
    for (int i = 0; i < 30; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      a = model_op(8'($urandom), ($urandom_range(0, 5) == 0) ? 8'sd0 : 8'($urandom));
      b = model_op(8'($urandom), ($urandom_range(0, 5) == 0) ? 8'sd0 : 8'($urandom));
      run_batch(m, a, b);
    end

    // Reset three edges into an operation, then a deferred new operation
    dividend0 = 8'd100; divisor0 = 8'd7; req0 = 1'b1;
    n = 0;
    while (!gnt0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("abort_grant", int'(gnt0), 1);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_gnt_zero", int'(gnt0 | gnt1), 0);
    chk("abort_busy_zero", int'(busy), 0);
    chk("abort_q_zero", int'(quotient), 0);
    chk("abort_r_zero", int'(remainder), 0);
    dividend0 = 8'd20; divisor0 = 8'd3;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", int'(done0 | done1), 0);
    end
    rst_n = 1'b1;
    n = 0;
    while (!gnt0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("deferred_grant", int'(gnt0), 1);
    lat = 0;
    while (!done0 && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("deferred_done", int'(done0), 1);
    chk("deferred_q", int'(quotient), 6);
    chk("deferred_r", int'(remainder), 2);
    chk("deferred_err", int'(err0), 0);
    chk("deferred_wait", int'(lat > 10), 1);
    req0 = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
